// File: rtl/srcnn_stream_framer.sv
// srcnn_stream_framer: re-emits the SRCNN RGB pixel stream as AXI4-Stream video (user = SOF, last = EOL)
// behind a registered-ready skid buffer. Define SRCNN_FRAMER_STATS_EN to add frame_count_o and overflow_o.
module srcnn_stream_framer #(
    parameter int Height          = 600,
    parameter int Width           = 800,
    parameter int ActivationWidth = 8
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         slave_valid_i,
    output logic                         slave_ready_o,
    input  logic [3*ActivationWidth-1:0] slave_data_i,
    output logic                         master_valid_o,
    input  logic                         master_ready_i,
    output logic [3*ActivationWidth-1:0] master_data_o,
    output logic                         master_user_o,
    output logic                         master_last_o,
    output logic                         frame_done_o
`ifdef SRCNN_FRAMER_STATS_EN
    ,
    output logic [15:0]                  frame_count_o,
    output logic                         overflow_o
`endif
);
    localparam int PixW = 3 * ActivationWidth;
    localparam int ColW = (Width > 1) ? $clog2(Width) : 1;
    localparam int RowW = (Height > 1) ? $clog2(Height) : 1;
    localparam logic [ColW-1:0] ColMax = ColW'(Width - 1);
    localparam logic [RowW-1:0] RowMax = RowW'(Height - 1);

    logic [ColW-1:0] col;
    logic [RowW-1:0] row;
    logic            main_valid;
    logic            main_eof;
    logic            skid_valid;
    logic            skid_valid_next;
    logic [PixW-1:0] skid_data;
    logic            skid_user;
    logic            skid_last;
    logic            skid_eof;
    logic            in_xfer;
    logic            out_xfer;
    logic            in_user;
    logic            in_last;
    logic            in_eof;

    assign in_xfer        = slave_valid_i & slave_ready_o;
    assign out_xfer       = main_valid & master_ready_i;
    assign in_user        = (col == '0) && (row == '0);
    assign in_last        = (col == ColMax);
    assign in_eof         = in_last && (row == RowMax);
    assign master_valid_o = main_valid;

    // The skid entry only fills when main is full and stalled; ready is the registered inverse of its next state.
    always_comb begin
        skid_valid_next = skid_valid;
        if (skid_valid && out_xfer) begin
            skid_valid_next = 1'b0;
        end else if (!skid_valid && main_valid && in_xfer && !out_xfer) begin
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            main_valid    <= 1'b0;
            master_data_o <= '0;
            master_user_o <= 1'b0;
            master_last_o <= 1'b0;
            main_eof      <= 1'b0;
            skid_valid    <= 1'b0;
            skid_data     <= '0;
            skid_user     <= 1'b0;
            skid_last     <= 1'b0;
            skid_eof      <= 1'b0;
            slave_ready_o <= 1'b0;
            frame_done_o  <= 1'b0;
        end else begin
            slave_ready_o <= !skid_valid_next;
            skid_valid    <= skid_valid_next;
            frame_done_o  <= out_xfer && main_eof;
            if (skid_valid) begin
                if (out_xfer) begin
                    master_data_o <= skid_data;
                    master_user_o <= skid_user;
                    master_last_o <= skid_last;
                    main_eof      <= skid_eof;
                end
            end else if (in_xfer && (!main_valid || out_xfer)) begin
                main_valid    <= 1'b1;
                master_data_o <= slave_data_i;
                master_user_o <= in_user;
                master_last_o <= in_last;
                main_eof      <= in_eof;
            end else if (in_xfer) begin
                skid_data <= slave_data_i;
                skid_user <= in_user;
                skid_last <= in_last;
                skid_eof  <= in_eof;
            end else if (out_xfer) begin
                main_valid <= 1'b0;
            end
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            col <= '0;
            row <= '0;
        end else if (in_xfer) begin
            if (in_last) begin
                col <= '0;
                row <= (row == RowMax) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

`ifdef SRCNN_FRAMER_STATS_EN
    logic [7:0] stall_cnt;

    // overflow_o latches once upstream has been refused for 256 consecutive cycles.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            frame_count_o <= '0;
            overflow_o    <= 1'b0;
            stall_cnt     <= '0;
        end else begin
            if (out_xfer && main_eof) begin
                frame_count_o <= frame_count_o + 16'd1;
            end
            if (slave_valid_i && !slave_ready_o) begin
                if (stall_cnt == 8'hFF) begin
                    overflow_o <= 1'b1;
                end else begin
                    stall_cnt <= stall_cnt + 8'd1;
                end
            end else begin
                stall_cnt <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_srcnn_stream_framer.sv
// Scoreboard bench for srcnn_stream_framer: a 2x3 instance for streaming scenarios and a 1x1 instance
// for the degenerate frame. Stats scenarios run when SRCNN_FRAMER_STATS_EN is defined.
module tb_srcnn_stream_framer;
    localparam int H  = 2;
    localparam int W  = 3;
    localparam int PW = 24;

    logic clock   = 1'b0;
    logic reset_i = 1'b0;
    always #5 clock = ~clock;

    logic          slave_valid  = 1'b0;
    logic          master_ready = 1'b0;
    logic [PW-1:0] slave_data   = '0;
    logic          slave_ready;
    logic          master_valid;
    logic [PW-1:0] master_data;
    logic          master_user;
    logic          master_last;
    logic          frame_done;

    logic          s1_valid = 1'b0;
    logic          m1_ready = 1'b0;
    logic [PW-1:0] s1_data  = '0;
    logic          s1_ready;
    logic          m1_valid;
    logic [PW-1:0] m1_data;
    logic          m1_user;
    logic          m1_last;
    logic          done1;

`ifdef SRCNN_FRAMER_STATS_EN
    logic [15:0] frame_count;
    logic        overflow;
    logic [15:0] frame_count1;
    logic        overflow1;
`endif

    srcnn_stream_framer #(.Height(H), .Width(W), .ActivationWidth(8)) dut (
        .clock_i(clock), .reset_i(reset_i),
        .slave_valid_i(slave_valid), .slave_ready_o(slave_ready), .slave_data_i(slave_data),
        .master_valid_o(master_valid), .master_ready_i(master_ready), .master_data_o(master_data),
        .master_user_o(master_user), .master_last_o(master_last), .frame_done_o(frame_done)
`ifdef SRCNN_FRAMER_STATS_EN
        , .frame_count_o(frame_count), .overflow_o(overflow)
`endif
    );

    srcnn_stream_framer #(.Height(1), .Width(1), .ActivationWidth(8)) dut1 (
        .clock_i(clock), .reset_i(reset_i),
        .slave_valid_i(s1_valid), .slave_ready_o(s1_ready), .slave_data_i(s1_data),
        .master_valid_o(m1_valid), .master_ready_i(m1_ready), .master_data_o(m1_data),
        .master_user_o(m1_user), .master_last_o(m1_last), .frame_done_o(done1)
`ifdef SRCNN_FRAMER_STATS_EN
        , .frame_count_o(frame_count1), .overflow_o(overflow1)
`endif
    );

    typedef struct packed {
        logic [PW-1:0] data;
        logic          user;
        logic          last;
        logic          eof;
    } pix_t;

    pix_t          exp_q[$];
    pix_t          exp_pix;
    int            n_compared = 0;
    int            n_failed   = 0;
    int            m_col      = 0;
    int            m_row      = 0;
    logic [PW-1:0] next_data  = 24'h000001;
    logic          done_expected = 1'b0;
    logic          next_done;
    logic          in_fire, out_fire, obs_valid, obs_ready, obs_user, obs_last, obs_done;
    logic [PW-1:0] obs_data;

    // One cycle on the 2x3 instance: drive, sample at negedge, and record accepted pixels with model tags.
    task automatic step(input logic v, input logic r);
        slave_valid  = v;
        master_ready = r;
        slave_data   = next_data;
        @(negedge clock);
        obs_ready = slave_ready;
        obs_valid = master_valid;
        obs_data  = master_data;
        obs_user  = master_user;
        obs_last  = master_last;
        obs_done  = frame_done;
        in_fire   = slave_valid & slave_ready;
        out_fire  = master_valid & master_ready;
        if (in_fire) begin
            exp_pix.data = next_data;
            exp_pix.user = (m_col == 0) && (m_row == 0);
            exp_pix.last = (m_col == W - 1);
            exp_pix.eof  = (m_col == W - 1) && (m_row == H - 1);
            exp_q.push_back(exp_pix);
            next_data = next_data + 24'd1;
            if (m_col == W - 1) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end else begin
                m_col = m_col + 1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_i      = 1'b0;
        slave_valid  = 1'b0;
        master_ready = 1'b0;
        s1_valid     = 1'b0;
        m1_ready     = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_i = 1'b1;
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        done_expected = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_i      = 1'b0;
        slave_valid  = 1'b1;
        slave_data   = 24'hABCDEF;
        master_ready = 1'b1;
        #1;
        n_compared++;
        if ({slave_ready, master_valid, master_data, master_user, master_last, frame_done, s1_ready, m1_valid, done1} !== '0) begin
            n_failed++;
            $display("[TB] FAIL reset_outputs got ready=%b valid=%b data=%h user=%b last=%b done=%b, expected all 0",
                     slave_ready, master_valid, master_data, master_user, master_last, frame_done);
        end
        @(negedge clock);
        @(negedge clock);
        n_compared++;
        if ({slave_ready, master_valid, master_data} !== '0) begin
            n_failed++;
            $display("[TB] FAIL reset_held got ready=%b valid=%b data=%h, expected 0", slave_ready, master_valid, master_data);
        end
        slave_valid = 1'b0;
        reset_i     = 1'b1;
        @(posedge clock);
        #1;
        n_compared++;
        if ({slave_ready, master_valid} !== 2'b10) begin
            n_failed++;
            $display("[TB] FAIL reset_release got ready=%b valid=%b, expected ready=1 valid=0", slave_ready, master_valid);
        end
    endtask

    task automatic test_basic_stream();
        int cyc = 0, first_in = -1, first_out = -1, last_out = -1, outs = 0, dones = 0, accepted = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(accepted < 6, 1'b1);
            if (in_fire) begin
                if (first_in < 0) first_in = cyc;
                accepted++;
            end
            next_done = 1'b0;
            if (obs_valid) begin
                n_compared++;
                if (exp_q.size() == 0) begin
                    n_failed++;
                    $display("[TB] FAIL basic_pixel got data=%h, expected no output", obs_data);
                end else if ({obs_data, obs_user, obs_last} !== {exp_q[0].data, exp_q[0].user, exp_q[0].last}) begin
                    n_failed++;
                    $display("[TB] FAIL basic_pixel got %h/u%b/l%b, expected %h/u%b/l%b",
                             obs_data, obs_user, obs_last, exp_q[0].data, exp_q[0].user, exp_q[0].last);
                end
                if (out_fire && exp_q.size() != 0) begin
                    exp_pix   = exp_q.pop_front();
                    next_done = exp_pix.eof;
                end
            end
            if (out_fire) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                outs++;
            end
            if (obs_done) dones++;
            n_compared++;
            if (obs_done !== done_expected) begin
                n_failed++;
                $display("[TB] FAIL basic_frame_done got %b, expected %b", obs_done, done_expected);
            end
            done_expected = next_done;
            cyc++;
        end
        n_compared++;
        if (first_out - first_in !== 1) begin
            n_failed++;
            $display("[TB] FAIL basic_latency got %0d, expected 1", first_out - first_in);
        end
        n_compared++;
        if (outs !== 6 || last_out - first_out !== 5) begin
            n_failed++;
            $display("[TB] FAIL basic_throughput got %0d outputs over %0d cycles, expected 6 over 5", outs, last_out - first_out);
        end
        n_compared++;
        if (dones !== 1) begin
            n_failed++;
            $display("[TB] FAIL basic_done_count got %0d, expected 1", dones);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1);
            if (out_fire) void'(exp_q.pop_front());
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            n_compared++;
            if (obs_ready !== (i == 0)) begin
                n_failed++;
                $display("[TB] FAIL stall_ready cycle %0d got %b, expected %b", i, obs_ready, (i == 0));
            end
            n_compared++;
            if (!obs_valid || {obs_data, obs_user, obs_last} !== {exp_q[0].data, exp_q[0].user, exp_q[0].last}) begin
                n_failed++;
                $display("[TB] FAIL stall_hold cycle %0d got v%b %h/u%b/l%b, expected v1 %h/u%b/l%b",
                         i, obs_valid, obs_data, obs_user, obs_last, exp_q[0].data, exp_q[0].user, exp_q[0].last);
            end
        end
        n_compared++;
        if (exp_q.size() !== 2) begin
            n_failed++;
            $display("[TB] FAIL stall_buffered got %0d, expected 2", exp_q.size());
        end
        for (int i = 0; i < 16 && (i < 6 || exp_q.size() != 0); i++) begin
            step(i < 6, 1'b1);
            if (obs_valid) begin
                n_compared++;
                if (exp_q.size() == 0) begin
                    n_failed++;
                    $display("[TB] FAIL resume_pixel got data=%h, expected no output", obs_data);
                end else if ({obs_data, obs_user, obs_last} !== {exp_q[0].data, exp_q[0].user, exp_q[0].last}) begin
                    n_failed++;
                    $display("[TB] FAIL resume_pixel got %h/u%b/l%b, expected %h/u%b/l%b",
                             obs_data, obs_user, obs_last, exp_q[0].data, exp_q[0].user, exp_q[0].last);
                end
                if (out_fire && exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
        n_compared++;
        if (exp_q.size() !== 0) begin
            n_failed++;
            $display("[TB] FAIL resume_drain got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_random();
        int accepted = 0, dones = 0, cyc = 0;
        do_reset();
        while (cyc < 60000 && (accepted < 1000 * H * W || exp_q.size() != 0)) begin
            if (accepted < 1000 * H * W) begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                step(1'b0, 1'b1);
            end
            if (in_fire) accepted++;
            if (obs_done) dones++;
            next_done = 1'b0;
            if (obs_valid) begin
                n_compared++;
                if (exp_q.size() == 0) begin
                    n_failed++;
                    $display("[TB] FAIL random_pixel got data=%h, expected no output", obs_data);
                end else if ({obs_data, obs_user, obs_last} !== {exp_q[0].data, exp_q[0].user, exp_q[0].last}) begin
                    n_failed++;
                    $display("[TB] FAIL random_pixel got %h/u%b/l%b, expected %h/u%b/l%b",
                             obs_data, obs_user, obs_last, exp_q[0].data, exp_q[0].user, exp_q[0].last);
                end
                if (out_fire && exp_q.size() != 0) begin
                    exp_pix   = exp_q.pop_front();
                    next_done = exp_pix.eof;
                end
            end
            n_compared++;
            if (obs_done !== done_expected) begin
                n_failed++;
                $display("[TB] FAIL random_frame_done got %b, expected %b", obs_done, done_expected);
            end
            done_expected = next_done;
            cyc++;
        end
        step(1'b0, 1'b1);
        if (obs_done) dones++;
        n_compared++;
        if (dones !== 1000 || accepted !== 1000 * H * W || exp_q.size() !== 0) begin
            n_failed++;
            $display("[TB] FAIL random_totals got dones=%0d accepted=%0d pending=%0d, expected 1000/6000/0",
                     dones, accepted, exp_q.size());
        end
    endtask

    task automatic test_reset_midframe();
        logic seen_first = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1);
            if (out_fire) void'(exp_q.pop_front());
        end
        reset_i = 1'b0;
        #1;
        n_compared++;
        if ({slave_ready, master_valid, master_data, master_user, master_last, frame_done} !== '0) begin
            n_failed++;
            $display("[TB] FAIL midreset_outputs got ready=%b valid=%b data=%h user=%b last=%b done=%b, expected all 0",
                     slave_ready, master_valid, master_data, master_user, master_last, frame_done);
        end
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(i < 3, 1'b1);
            if (obs_valid) begin
                n_compared++;
                if (exp_q.size() == 0) begin
                    n_failed++;
                    $display("[TB] FAIL midreset_pixel got stale data=%h, expected no output", obs_data);
                end else if ({obs_data, obs_user, obs_last} !== {exp_q[0].data, exp_q[0].user, exp_q[0].last}) begin
                    n_failed++;
                    $display("[TB] FAIL midreset_pixel got %h/u%b/l%b, expected %h/u%b/l%b",
                             obs_data, obs_user, obs_last, exp_q[0].data, exp_q[0].user, exp_q[0].last);
                end
                if (!seen_first) begin
                    seen_first = 1'b1;
                    n_compared++;
                    if (obs_user !== 1'b1) begin
                        n_failed++;
                        $display("[TB] FAIL midreset_first_user got %b, expected 1", obs_user);
                    end
                end
                if (out_fire && exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
        n_compared++;
        if (!seen_first || exp_q.size() !== 0) begin
            n_failed++;
            $display("[TB] FAIL midreset_drain got seen=%b pending=%0d, expected seen=1 pending=0", seen_first, exp_q.size());
        end
    endtask

    task automatic test_single_pixel();
        logic [PW-1:0] q1[$];
        logic [PW-1:0] d1 = 24'h100000;
        int dones = 0, outs = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            s1_valid = (q1.size() + outs) < 5;
            s1_data  = d1;
            m1_ready = (i % 4) != 2;
            @(negedge clock);
            if (done1) dones++;
            if (m1_valid) begin
                n_compared++;
                if (q1.size() == 0 || {m1_data, m1_user, m1_last} !== {q1[0], 2'b11}) begin
                    n_failed++;
                    $display("[TB] FAIL single_pixel got %h/u%b/l%b, expected %h/u1/l1",
                             m1_data, m1_user, m1_last, (q1.size() != 0) ? q1[0] : '0);
                end
                if (m1_ready && q1.size() != 0) begin
                    void'(q1.pop_front());
                    outs++;
                end
            end
            if (s1_valid && s1_ready) begin
                q1.push_back(d1);
                d1 = d1 + 24'd1;
            end
            @(posedge clock);
            #1;
        end
        n_compared++;
        if (outs !== 5 || dones !== 5) begin
            n_failed++;
            $display("[TB] FAIL single_done_count got outs=%0d dones=%0d, expected 5/5", outs, dones);
        end
    endtask

`ifdef SRCNN_FRAMER_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 30; i++) begin
            step(i < 3 * H * W, 1'b1);
        end
        n_compared++;
        if (frame_count !== 16'd3) begin
            n_failed++;
            $display("[TB] FAIL stats_frame_count got %0d, expected 3", frame_count);
        end
        do_reset();
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0);
        n_compared++;
        if (overflow !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL stats_overflow_early got %b, expected 0", overflow);
        end
        for (int i = 0; i < 200; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        n_compared++;
        if (overflow !== 1'b1) begin
            n_failed++;
            $display("[TB] FAIL stats_overflow_sticky got %b, expected 1", overflow);
        end
        do_reset();
        n_compared++;
        if ({overflow, frame_count} !== '0) begin
            n_failed++;
            $display("[TB] FAIL stats_reset got overflow=%b count=%0d, expected 0/0", overflow, frame_count);
        end
    endtask
`endif

    initial begin
        $display("[TB] srcnn_stream_framer bench start");
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_reset_midframe();
        test_single_pixel();
        test_random();
`ifdef SRCNN_FRAMER_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
